// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the fetch stage and its pipeline register.
package riscv_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0 -- canonical bubble encoding
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  // Fetch FSM: IDLE issues a request, WAIT has one outstanding, HOLD keeps a
  // returned instruction while IF/ID is stalled, DROP swallows a stale response.
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: write enable, flush and bubble insertion.
// A bubble keeps the PC field and replaces the instruction with the NOP.
module if_id_register #(
  parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic                       flush,
  input  logic                       instr_valid,
  input  logic [riscv_pkg::XLEN-1:0] fetch_pc,
  input  logic [riscv_pkg::XLEN-1:0] fetch_instr,
  output logic [riscv_pkg::XLEN-1:0] id_pc,
  output logic [riscv_pkg::XLEN-1:0] id_instr,
  output logic                       id_valid
);
  import riscv_pkg::*;

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] instr_reg;
  logic            valid_reg;

  // Flush beats everything; otherwise write loads a real instruction or a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg    <= '0;
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (flush || (write_en && !instr_valid)) begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (write_en) begin
      pc_reg    <= fetch_pc;
      instr_reg <= fetch_instr;
      valid_reg <= 1'b1;
    end
  end

  assign id_pc    = pc_reg;
  assign id_instr = instr_reg;
  assign id_valid = valid_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, single-outstanding fetch FSM with a
// one-entry hold buffer for stalls, and the IF/ID pipeline register.
module if_stage #(
  parameter logic [riscv_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [riscv_pkg::XLEN-1:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       PCwrite,
  input  logic                       IF_IDwrite,
  input  logic                       PCSrc,
  input  logic [riscv_pkg::XLEN-1:0] PC_branch,
  output logic                       imem_req,
  output logic [riscv_pkg::XLEN-1:0] imem_addr,
  input  logic                       imem_ready,
  input  logic                       imem_rvalid,
  input  logic [riscv_pkg::XLEN-1:0] imem_rdata,
  output logic [riscv_pkg::XLEN-1:0] PC_IF_ID,
  output logic [riscv_pkg::XLEN-1:0] INSTR_IF_ID,
  output logic                       valid_IF_ID
);
  import riscv_pkg::*;

  fetch_state_t    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] hold_pc_reg, hold_pc_next;
  logic [XLEN-1:0] hold_instr_reg, hold_instr_next;
  logic            handshake;
  logic            deliver;
  logic [XLEN-1:0] deliver_pc;
  logic [XLEN-1:0] deliver_instr;

  // Requests only come from IDLE; reset gates the request off combinationally
  assign imem_req  = (state_reg == FETCH_IDLE) && !reset;
  assign imem_addr = pc_reg;
  assign handshake = imem_req && imem_ready;

  // State, PC and hold buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= FETCH_IDLE;
      pc_reg         <= {RESET_PC[XLEN-1:2], 2'b00};
      hold_pc_reg    <= '0;
      hold_instr_reg <= NOP_INSTR;
    end else begin
      state_reg      <= state_next;
      pc_reg         <= pc_next;
      hold_pc_reg    <= hold_pc_next;
      hold_instr_reg <= hold_instr_next;
    end
  end

  // Next-state, PC update and delivery selection; a redirect overrides all
  always_comb begin
    state_next      = state_reg;
    pc_next         = pc_reg;
    hold_pc_next    = hold_pc_reg;
    hold_instr_next = hold_instr_reg;
    deliver         = 1'b0;
    deliver_pc      = pc_reg;
    deliver_instr   = imem_rdata;

    case (state_reg)
      FETCH_IDLE: begin
        if (handshake) state_next = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        if (imem_rvalid) begin
          if (IF_IDwrite) begin
            deliver    = 1'b1;
            state_next = FETCH_IDLE;
            if (PCwrite) pc_next = pc_reg + 32'd4;
          end else begin
            hold_pc_next    = pc_reg;
            hold_instr_next = imem_rdata;
            state_next      = FETCH_HOLD;
          end
        end
      end
      FETCH_HOLD: begin
        deliver_pc    = hold_pc_reg;
        deliver_instr = hold_instr_reg;
        if (IF_IDwrite) begin
          deliver    = 1'b1;
          state_next = FETCH_IDLE;
          if (PCwrite) pc_next = pc_reg + 32'd4;
        end
      end
      FETCH_DROP: begin
        if (imem_rvalid) state_next = FETCH_IDLE;
      end
      default: state_next = FETCH_IDLE;
    endcase

    if (PCSrc) begin
      pc_next = PC_branch & ~32'h3;
      deliver = 1'b0;
      case (state_reg)
        FETCH_IDLE: state_next = handshake ? FETCH_DROP : FETCH_IDLE;
        FETCH_WAIT: state_next = imem_rvalid ? FETCH_IDLE : FETCH_DROP;
        FETCH_HOLD: state_next = FETCH_IDLE;
        // A response landing in the same cycle settles the drop, otherwise
        // we would wait forever for a response that has already gone by.
        FETCH_DROP: state_next = imem_rvalid ? FETCH_IDLE : FETCH_DROP;
        default:    state_next = FETCH_IDLE;
      endcase
    end
  end

  if_id_register #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .write_en   (IF_IDwrite),
    .flush      (PCSrc),
    .instr_valid(deliver),
    .fetch_pc   (deliver_pc),
    .fetch_instr(deliver_instr),
    .id_pc      (PC_IF_ID),
    .id_instr   (INSTR_IF_ID),
    .id_valid   (valid_IF_ID)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed cycle-by-cycle vectors for the fetch stage plus a streaming
// sequence against a small 1-cycle-latency memory model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        PCwrite = 1'b1;
  logic        IF_IDwrite = 1'b1;
  logic        PCSrc = 1'b0;
  logic [31:0] PC_branch = '0;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] PC_IF_ID;
  logic [31:0] INSTR_IF_ID;
  logic        valid_IF_ID;

  localparam logic [31:0] NOP = 32'h0000_0013;

  always #5 clk = ~clk;

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .PCwrite    (PCwrite),
    .IF_IDwrite (IF_IDwrite),
    .PCSrc      (PCSrc),
    .PC_branch  (PC_branch),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .PC_IF_ID   (PC_IF_ID),
    .INSTR_IF_ID(INSTR_IF_ID),
    .valid_IF_ID(valid_IF_ID)
  );

  typedef struct {
    logic        rst, pcw, ifw, pcsrc;
    logic [31:0] br;
    logic        rdy, rv;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_addr, e_pc, e_ins;
    logic        e_v;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // stream sequence state
  logic        pend, hs;
  logic [31:0] pend_addr, cur_addr, exp_pc;
  int          got, cyc;

  function automatic void add(input logic rst, pcw, ifw, pcsrc, input logic [31:0] br,
                              input logic rdy, rv, input logic [31:0] rd,
                              input logic e_req, input logic [31:0] e_addr, e_pc, e_ins,
                              input logic e_v);
    vec_t v;
    v.rst = rst; v.pcw = pcw; v.ifw = ifw; v.pcsrc = pcsrc; v.br = br;
    v.rdy = rdy; v.rv = rv; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_ins = e_ins; v.e_v = e_v;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  initial begin
    //   rst pcw ifw src br            rdy rv rd              req addr          pc            ins           v
    // reset, then straight-line fetch 0,4,8
    add(1, 1, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         32'h0,        NOP,          0); // 0
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         32'h0,        NOP,          0); // 1
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hA000_0000, 0, 32'h0,         32'h0,        32'hA000_0000,1); // 2
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h4,         32'h0,        NOP,          0); // 3
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hA000_0004, 0, 32'h4,         32'h4,        32'hA000_0004,1); // 4
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h8,         32'h4,        NOP,          0); // 5
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hA000_0008, 0, 32'h8,         32'h8,        32'hA000_0008,1); // 6
    // stall 3 cycles while the response returns -> HOLD, then release
    add(0, 1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'hC,         32'h8,        32'hA000_0008,1); // 7
    add(0, 0, 0, 0, 32'h0,         1, 1, 32'hA000_000C, 0, 32'hC,         32'h8,        32'hA000_0008,1); // 8
    add(0, 0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'hC,         32'h8,        32'hA000_0008,1); // 9
    add(0, 0, 0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 32'hC,         32'h8,        32'hA000_0008,1); // 10
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 32'hC,         32'hC,        32'hA000_000C,1); // 11
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h10,        32'hC,        NOP,          0); // 12
    // redirect in WAIT without rvalid -> DROP; stale response discarded
    add(0, 1, 1, 1, 32'h100,       1, 0, 32'h0,         0, 32'h10,        32'hC,        NOP,          0); // 13
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h100,       32'hC,        NOP,          0); // 14
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hBAD0_0010, 0, 32'h100,       32'hC,        NOP,          0); // 15
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       32'hC,        NOP,          0); // 16
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hA000_0100, 0, 32'h100,       32'h100,      32'hA000_0100,1); // 17
    // redirect with IF_IDwrite=0, misaligned target 0x103 -> 0x100; no handshake
    add(0, 0, 0, 1, 32'h103,       0, 0, 32'h0,         1, 32'h104,       32'h100,      NOP,          0); // 18
    add(0, 1, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h100,       32'h100,      NOP,          0); // 19
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h100,       32'h100,      NOP,          0); // 20
    // redirect in WAIT with rvalid same cycle -> IDLE; then wrap at 0xFFFFFFFC
    add(0, 1, 1, 1, 32'hFFFF_FFFC, 1, 1, 32'hBAD0_0100, 0, 32'h100,       32'h100,      NOP,          0); // 21
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h100,      NOP,          0); // 22
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hC0DE_FFFC, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC,32'hC0DE_FFFC,1); // 23
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         32'hFFFF_FFFC,NOP,          0); // 24
    // reset while in WAIT, late rvalid in first IDLE cycle ignored
    add(1, 1, 1, 0, 32'h0,         1, 0, 32'h0,         0, 32'h0,         32'h0,        NOP,          0); // 25
    add(0, 1, 1, 0, 32'h0,         0, 1, 32'hBAD0_0000, 1, 32'h0,         32'h0,        NOP,          0); // 26
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h0,         32'h0,        NOP,          0); // 27
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hA000_0000, 0, 32'h0,         32'h0,        32'hA000_0000,1); // 28
    // redirect in IDLE with handshake -> DROP
    add(0, 1, 1, 1, 32'h200,       1, 0, 32'h0,         1, 32'h4,         32'h0,        NOP,          0); // 29
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hBAD0_0004, 0, 32'h200,       32'h0,        NOP,          0); // 30
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h200,       32'h0,        NOP,          0); // 31
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hA000_0200, 0, 32'h200,       32'h200,      32'hA000_0200,1); // 32
    // redirect while in HOLD -> buffer discarded
    add(0, 1, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h204,       32'h200,      32'hA000_0200,1); // 33
    add(0, 0, 0, 0, 32'h0,         1, 1, 32'hA000_0204, 0, 32'h204,       32'h200,      32'hA000_0200,1); // 34
    add(0, 0, 0, 1, 32'h300,       1, 0, 32'h0,         0, 32'h204,       32'h200,      NOP,          0); // 35
    add(0, 1, 1, 0, 32'h0,         1, 0, 32'h0,         1, 32'h300,       32'h200,      NOP,          0); // 36
    add(0, 1, 1, 0, 32'h0,         1, 1, 32'hA000_0300, 0, 32'h300,       32'h300,      32'hA000_0300,1); // 37

    // initial reset so the PC is defined before the table starts
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset       = vecs[i].rst;
      PCwrite     = vecs[i].pcw;
      IF_IDwrite  = vecs[i].ifw;
      PCSrc       = vecs[i].pcsrc;
      PC_branch   = vecs[i].br;
      imem_ready  = vecs[i].rdy;
      imem_rvalid = vecs[i].rv;
      imem_rdata  = vecs[i].rd;
      #1;
      chk("imem_req", i, {31'b0, imem_req}, {31'b0, vecs[i].e_req});
      chk("imem_addr", i, imem_addr, vecs[i].e_addr);
      @(posedge clk);
      #1;
      chk("PC_IF_ID", i, PC_IF_ID, vecs[i].e_pc);
      chk("INSTR_IF_ID", i, INSTR_IF_ID, vecs[i].e_ins);
      chk("valid_IF_ID", i, {31'b0, valid_IF_ID}, {31'b0, vecs[i].e_v});
      $display("vec %0d: req=%0b addr=%h -> IF/ID pc=%h instr=%h valid=%0b",
               i, imem_req, imem_addr, PC_IF_ID, INSTR_IF_ID, valid_IF_ID);
    end

    // streaming fetch from 0x304 against a 1-cycle-latency memory
    pend = 1'b0; pend_addr = '0; exp_pc = 32'h304; got = 0; cyc = 0;
    PCwrite = 1'b1; IF_IDwrite = 1'b1; PCSrc = 1'b0; imem_ready = 1'b1;
    while (got < 3 && cyc < 40) begin
      @(negedge clk);
      imem_rvalid = pend;
      imem_rdata  = 32'hA000_0000 | pend_addr;
      #1;
      hs       = imem_req && imem_ready;
      cur_addr = imem_addr;
      @(posedge clk);
      #1;
      pend      = hs;
      pend_addr = cur_addr;
      cyc++;
      if (valid_IF_ID) begin
        chk("stream_pc", got, PC_IF_ID, exp_pc);
        chk("stream_instr", got, INSTR_IF_ID, 32'hA000_0000 | exp_pc);
        $display("stream %0d: IF/ID pc=%h instr=%h at cycle %0d", got, PC_IF_ID, INSTR_IF_ID, cyc);
        exp_pc = exp_pc + 32'd4;
        got++;
      end
    end
    if (got < 3) begin
      n_vec++;
      n_bad++;
      $display("FAIL stream_timeout: got %0d instructions, required 3", got);
    end else begin
      chk("stream_cycles", 0, cyc, 32'd6);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
